// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^n) multiplier: default polynomial, FSM states
// and the xtime (multiply-by-x) helper.
package gf_pkg;

    localparam logic [7:0] KUZ_POLY = 8'hC3;
    localparam int unsigned XW = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Generic-width xtime; operands live in the low w bits of a 64-bit carrier (w < 64).
    function automatic logic [XW-1:0] xtime(input logic [XW-1:0] v,
                                            input int unsigned w,
                                            input logic [XW-1:0] poly);
        logic [XW-1:0] mask;
        logic [XW-1:0] r;
        mask = (XW'(1) << w) - XW'(1);
        r    = (v << 1) & mask;
        if (v[w-1]) begin
            r = r ^ (poly & mask);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_mul_step.sv
// One clock's worth of the MSB-first shift-and-add: DIGIT unrolled
// xtime/conditional-xor sub-steps applied to the accumulator.
module gf_mul_step
    import gf_pkg::*;
#(
    parameter int unsigned         WIDTH = 8,
    parameter logic [WIDTH-1:0]    POLY  = KUZ_POLY,
    parameter int unsigned         DIGIT = 1
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [DIGIT-1:0] i_bits,
    output logic [WIDTH-1:0] o_next_acc
);

    logic [XW-1:0] w_t;

    always_comb begin
        w_t = XW'(i_acc);
        for (int unsigned i = 0; i < DIGIT; i++) begin
            w_t = xtime(w_t, WIDTH, XW'(POLY)) ^ (i_bits[DIGIT-1-i] ? XW'(i_a) : '0);
        end
        o_next_acc = w_t[WIDTH-1:0];
    end

endmodule

// File: rtl/gf_mul_iter.sv
// Iterative GF(2^WIDTH) multiplier, DIGIT bits of b per clock, valid/ready on both sides.
// Optional zero-operand shortcut enabled by defining GF_MUL_EARLY_OUT_EN.
module gf_mul_iter
    import gf_pkg::*;
#(
    parameter int unsigned         WIDTH = 8,
    parameter logic [WIDTH-1:0]    POLY  = KUZ_POLY,
    parameter int unsigned         DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             busy
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("gf_mul_iter: WIDTH must be a multiple of DIGIT");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_next_acc;
    logic               w_last;
    logic               w_zero;
    logic               w_accept;

`ifdef GF_MUL_EARLY_OUT_EN
    assign w_zero = (a == '0) || (b == '0);
`else
    assign w_zero = 1'b0;
`endif

    gf_mul_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .DIGIT (DIGIT)
    ) u_step (
        .i_acc      (r_acc),
        .i_a        (r_a),
        .i_bits     (r_b[WIDTH-1 -: DIGIT]),
        .o_next_acc (w_next_acc)
    );

    assign w_last   = (r_cnt == CNT_W'(STEPS - 1));
    assign w_accept = (r_state == IDLE) && in_valid;
    assign c        = r_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
            if (w_zero) begin
                r_c <= '0;
            end
        end else if (r_state == RUN) begin
            r_acc <= w_next_acc;
            r_b   <= r_b << DIGIT;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_c <= w_next_acc;
            end
        end
    end

endmodule

// File: tb/tb_gf_mul_iter.sv
// Scoreboard bench for gf_mul_iter: four configurations share one stimulus stream
// (DIGIT 1/2/4 with the Kuznechik polynomial, DIGIT 1 with the AES polynomial).
module tb_gf_mul_iter;

    typedef struct {
        logic [7:0]  exp;
        int unsigned t0;
        int unsigned lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_valid = '0;
    logic [3:0] in_ready;
    logic [3:0] out_valid;
    logic [3:0] busy;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] c_o [4];

    exp_t        sb [4][$];
    logic [3:0]  seen = '0;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf_mul_iter #(.WIDTH(8), .POLY(8'hC3), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
        .c(c_o[0]), .busy(busy[0]));
    gf_mul_iter #(.WIDTH(8), .POLY(8'hC3), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
        .c(c_o[1]), .busy(busy[1]));
    gf_mul_iter #(.WIDTH(8), .POLY(8'hC3), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready),
        .c(c_o[2]), .busy(busy[2]));
    gf_mul_iter #(.WIDTH(8), .POLY(8'h1B), .DIGIT(1)) u_aes (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a), .b(b), .out_valid(out_valid[3]), .out_ready(out_ready),
        .c(c_o[3]), .busy(busy[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // LSB-first reference product, independent of the DUT's MSB-first ordering.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] poly);
        logic [7:0] p = '0;
        logic [7:0] t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = t[7] ? ((t << 1) ^ poly) : (t << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] poly_of(input int i);
        return (i == 3) ? 8'h1B : 8'hC3;
    endfunction

    function automatic int unsigned steps_of(input int i);
        return (i == 1) ? 4 : (i == 2) ? 2 : 8;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    if (sb[i].size() == 0) begin
                        check($sformatf("unexpected_valid[%0d]", i), 1, 0);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        check($sformatf("c[%0d]", i), c_o[i], e.exp);
                        check($sformatf("latency[%0d]", i), cyc - e.t0, e.lat);
                    end
                end else if (!out_valid[i]) begin
                    seen[i] = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input logic [3:0] mask);
        int n = 0;
        while (((in_ready & mask) != mask) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] mask);
        wait_idle(mask);
        a = ia;
        b = ib;
        in_valid = mask;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                exp_t e;
                e.exp = gmul(ia, ib, poly_of(i));
                e.t0  = cyc + 1;
                e.lat = steps_of(i);
`ifdef GF_MUL_EARLY_OUT_EN
                if (ia == 8'h00 || ib == 8'h00) e.lat = 1;
`endif
                sb[i].push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        a = 8'($urandom);
        b = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
    endtask

    initial begin
        logic [7:0] va [9];
        logic [7:0] vb [9];
        int n;
        va = '{8'h57, 8'hFF, 8'h80, 8'h10, 8'h02, 8'h00, 8'h5A, 8'h01, 8'hC7};
        vb = '{8'h83, 8'hFF, 8'h80, 8'h20, 8'h87, 8'h5A, 8'h00, 8'hC7, 8'h01};

        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
            check($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
            check($sformatf("rst_busy[%0d]", i), busy[i], 0);
            check($sformatf("rst_c[%0d]", i), c_o[i], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, then random ones, all back-to-back with out_ready=1
        for (int k = 0; k < 9; k++) begin
            do_op(va[k], vb[k], 4'hF);
            if (k == 0) check("busy_in_run", busy[0], 1);
        end
        for (int k = 0; k < 8; k++) begin
            do_op(8'($urandom), 8'($urandom), 4'hF);
        end
        drain();

        // Backpressure: result must hold and new requests must be ignored
        out_ready = 1'b0;
        do_op(8'h57, 8'h83, 4'hF);
        n = 0;
        while (out_valid != 4'hF && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_timeout", out_valid, 4'hF);
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'hF;
            a = 8'h11;
            b = 8'h22;
            @(negedge clk);
            check("bp_c_stable", c_o[0], gmul(8'h57, 8'h83, 8'hC3));
            check("bp_in_ready", in_ready[0], 0);
            check("bp_out_valid", out_valid[0], 1);
        end
        in_valid = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", out_valid[0], 0);
        check("bp_release_ready", in_ready[0], 1);
        check("bp_c_kept", c_o[0], gmul(8'h57, 8'h83, 8'hC3));
        @(negedge clk);
        drain();
        do_op(8'h10, 8'h20, 4'hF);
        drain();

        // Reset during the 4th RUN cycle discards the pending result
        wait_idle(4'b0001);
        a = 8'hAB;
        b = 8'hC4;
        in_valid = 4'b0001;
        @(posedge clk);
        #1;
        in_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy[0], 0);
        check("async_rst_in_ready", in_ready[0], 1);
        check("async_rst_out_valid", out_valid[0], 0);
        check("async_rst_c", c_o[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_op(8'hAB, 8'hC4, 4'hF);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
